// File: rtl/asym_buf_pkg.sv
// Shared types and constants for the asymmetric buffer playback sequencer.
package asym_buf_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam int unsigned SKID_DEPTH = 2;

  // Ceiling log2; exact for the power-of-two width ratios used here.
  function automatic int unsigned log2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/playback_skid_fifo.sv
// Two-entry skid FIFO holding narrow read words ahead of the output stream.
module playback_skid_fifo
  import asym_buf_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [SKID_DEPTH];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;

  always_comb begin
    count_d = count_q + 2'(push_i) - 2'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
      for (int unsigned i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/asym_buf_playback_ctrl.sv
// Load/playback sequencer for the write-wide/read-narrow buffer RAM:
// wide host writes in IDLE, credit-limited narrow reads streamed out in RUN/DRAIN.
module asym_buf_playback_ctrl
  import asym_buf_pkg::*;
#(
  parameter int unsigned DATAWIDTHA = 16,
  parameter int unsigned ADDRWIDTHA = 8,
  parameter int unsigned DATAWIDTHB = 4,
  parameter int unsigned ADDRWIDTHB = 10
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [ADDRWIDTHA-1:0] ld_addr,
  input  logic [DATAWIDTHA-1:0] ld_data,
  input  logic                  start,
  input  logic                  stop,
  input  logic [ADDRWIDTHB-1:0] base,
  input  logic [ADDRWIDTHB:0]   length,
  input  logic                  loop,
  output logic                  busy,
  output logic                  done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATAWIDTHB-1:0] out_data,
  output logic                  ram_weA,
  output logic                  ram_enaA,
  output logic [ADDRWIDTHA-1:0] ram_addrA,
  output logic [DATAWIDTHA-1:0] ram_diA,
  output logic                  ram_enaB,
  output logic [ADDRWIDTHB-1:0] ram_addrB,
  input  logic [DATAWIDTHB-1:0] ram_doB
);

  localparam int unsigned RATIO     = DATAWIDTHA / DATAWIDTHB;
  localparam int unsigned LOG2RATIO = log2(RATIO);

  if ((ADDRWIDTHB != ADDRWIDTHA + LOG2RATIO) || ((1 << LOG2RATIO) != RATIO)) begin : g_cfg_check
    $error("asym_buf_playback_ctrl: inconsistent width/address parameters");
  end

  state_t                state_q, state_d;
  logic [ADDRWIDTHB-1:0] base_q, base_d;
  logic [ADDRWIDTHB:0]   len_q, len_d;
  logic [ADDRWIDTHB:0]   off_q, off_d;
  logic                  loop_q, loop_d;
  logic [1:0]            credits_q, credits_d;
  logic                  pend_q, pend_d;
  logic                  done_q, done_d;

  logic                  issue, flush, accept, wr, drain_done;
  logic                  fifo_push, fifo_pop, fifo_nonempty;
  logic [DATAWIDTHB-1:0] fifo_dout;
  logic [1:0]            fifo_count;

  playback_skid_fifo #(.W(DATAWIDTHB)) u_skid (
    .clk     (clk),
    .rstn    (rstn),
    .flush_i (flush),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (ram_doB),
    .dout_o  (fifo_dout),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    off_d      = off_q;
    loop_d     = loop_q;
    done_d     = 1'b0;
    issue      = 1'b0;
    flush      = 1'b0;
    drain_done = 1'b0;

    // Empty FIFO falls through to the RAM output so the first word leaves one cycle after its read.
    fifo_nonempty = (fifo_count != '0);
    out_valid     = fifo_nonempty | pend_q;
    out_data      = fifo_nonempty ? fifo_dout : (pend_q ? ram_doB : '0);
    accept        = out_valid & out_ready;
    fifo_pop      = accept & fifo_nonempty;
    fifo_push     = pend_q & ~(accept & ~fifo_nonempty);

    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          if (length == '0) begin
            done_d = 1'b1;
          end else begin
            base_d  = base;
            len_d   = length;
            loop_d  = loop;
            off_d   = '0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (stop) begin
          flush   = 1'b1;
          state_d = IDLE;
        end else if (credits_q < 2'(SKID_DEPTH)) begin
          issue = 1'b1;
          if (off_q == len_q - (ADDRWIDTHB+1)'(1)) begin
            off_d = '0;
            if (!loop_q) state_d = DRAIN;
          end else begin
            off_d = off_q + (ADDRWIDTHB+1)'(1);
          end
        end
      end
      DRAIN: begin
        if (stop) begin
          flush   = 1'b1;
          state_d = IDLE;
        end else if (accept && credits_q == 2'd1) begin
          drain_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    credits_d = flush ? '0 : credits_q + 2'(issue) - 2'(accept);
    pend_d    = issue;

    wr        = (state_q == IDLE) & ld_valid;
    ld_ready  = (state_q == IDLE);
    ram_enaA  = wr;
    ram_weA   = wr;
    ram_addrA = wr ? ld_addr : '0;
    ram_diA   = wr ? ld_data : '0;
    ram_enaB  = issue;
    ram_addrB = issue ? base_q + off_q[ADDRWIDTHB-1:0] : '0;
    busy      = (state_q != IDLE);
    done      = done_q | drain_done;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      base_q    <= '0;
      len_q     <= '0;
      off_q     <= '0;
      loop_q    <= 1'b0;
      credits_q <= '0;
      pend_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      off_q     <= off_d;
      loop_q    <= loop_d;
      credits_q <= credits_d;
      pend_q    <= pend_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_asym_buf_playback_ctrl.sv
// Scoreboard bench for asym_buf_playback_ctrl with a behavioural asymmetric RAM.
module tb_asym_buf_playback_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ld_valid, ld_ready;
  logic [7:0]  ld_addr;
  logic [15:0] ld_data;
  logic        start, stop, loop;
  logic [9:0]  base;
  logic [10:0] length;
  logic        busy, done;
  logic        out_valid, out_ready;
  logic [3:0]  out_data;
  logic        ram_weA, ram_enaA;
  logic [7:0]  ram_addrA;
  logic [15:0] ram_diA;
  logic        ram_enaB;
  logic [9:0]  ram_addrB;
  logic [3:0]  ram_doB;

  int n_chk  = 0;
  int n_fail = 0;
  int tb_out = 0;
  logic [3:0] exp_word [$];
  logic [9:0] exp_addr [$];

  always #5 clk = ~clk;

  asym_buf_playback_ctrl #(
    .DATAWIDTHA(16), .ADDRWIDTHA(8), .DATAWIDTHB(4), .ADDRWIDTHB(10)
  ) dut (
    .clk(clk), .rstn(rstn),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .stop(stop), .base(base), .length(length), .loop(loop),
    .busy(busy), .done(done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ram_weA(ram_weA), .ram_enaA(ram_enaA), .ram_addrA(ram_addrA), .ram_diA(ram_diA),
    .ram_enaB(ram_enaB), .ram_addrB(ram_addrB), .ram_doB(ram_doB)
  );

  logic [3:0] mem [1024];
  always @(posedge clk) begin
    if (ram_enaA && ram_weA)
      for (int k = 0; k < 4; k++) mem[{ram_addrA, 2'(k)}] <= ram_diA[k*4 +: 4];
    if (ram_enaB) ram_doB <= mem[ram_addrB];
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rstn) begin
        tb_out = 0;
      end else begin
        if (ram_enaB) begin
          chk("issue_within_credit", int'(tb_out < 2), 1);
          if (exp_addr.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_issue: got addr 0x%0h, expected no read", ram_addrB);
          end else chk("ram_addrB", int'(ram_addrB), int'(exp_addr.pop_front()));
        end
        if (out_valid && out_ready) begin
          if (exp_word.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_word: got 0x%0h, expected no word", out_data);
          end else chk("out_data", int'(out_data), int'(exp_word.pop_front()));
        end
        tb_out = tb_out + int'(ram_enaB) - int'(out_valid && out_ready);
        if (stop && busy) tb_out = 0;
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ld_ready"}, int'(ld_ready), 1);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_data"}, int'(out_data), 0);
    chk({tag, "_ram_enaA"}, int'(ram_enaA | ram_weA), 0);
    chk({tag, "_ram_enaB"}, int'(ram_enaB), 0);
    chk({tag, "_ram_addrA"}, int'(ram_addrA), 0);
    chk({tag, "_ram_addrB"}, int'(ram_addrB), 0);
  endtask

  task automatic load(input logic [7:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    chk("load_ld_ready", int'(ld_ready), 1);
    chk("load_ram_weA", int'(ram_enaA & ram_weA), 1);
    @(posedge clk); #1;
    ld_valid = 1'b0;
  endtask

  // Cycle 0 carries start; cycle c is the c-th clock after it.
  task automatic play(input logic [9:0] b, input logic [10:0] len, input logic lp,
                      input logic [3:0] pat, input int stop_cyc, output int done_cyc);
    @(posedge clk); #1;
    base = b; length = len; loop = lp; start = 1'b1; stop = 1'b0; out_ready = pat[0];
    done_cyc = -1;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk); #1;
      start     = 1'b0;
      stop      = (c == stop_cyc);
      out_ready = (c == stop_cyc) ? 1'b0 : pat[c % 4];
      @(negedge clk);
      if (c == 1) begin
        chk("busy_cycle1", int'(busy), int'(len != 0));
        chk("enaB_cycle1", int'(ram_enaB), int'(len != 0));
      end
      if (done && done_cyc < 0) done_cyc = c;
      if (stop_cyc > 0 && c == stop_cyc + 1) begin
        chk("out_valid_after_stop", int'(out_valid), 0);
        chk("busy_after_stop", int'(busy), 0);
        break;
      end
      if (stop_cyc < 0 && done_cyc >= 0 && c == done_cyc + 1) begin
        chk("busy_after_done", int'(busy), 0);
        chk("done_one_cycle", int'(done), 0);
        break;
      end
    end
    out_ready = 1'b1;
  endtask

  task automatic stimulus();
    int dc;
    rstn = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    start = 1'b0; stop = 1'b0; base = '0; length = '0; loop = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1;
    rstn = 1'b1;

    load(8'd0, 16'h3210);
    load(8'd1, 16'h7654);
    load(8'd255, 16'hFEDC);

    // Straight playback, out_ready high
    for (int i = 0; i < 8; i++) begin exp_addr.push_back(10'(i)); exp_word.push_back(4'(i)); end
    play(10'd0, 11'd8, 1'b0, 4'b1111, -1, dc);
    chk("done_cycle_len8", dc, 9);
    chk("words_drained_len8", exp_word.size(), 0);

    // Same window with out_ready 1,0,0,1
    for (int i = 0; i < 8; i++) begin exp_addr.push_back(10'(i)); exp_word.push_back(4'(i)); end
    play(10'd0, 11'd8, 1'b0, 4'b1001, -1, dc);
    chk("done_seen_stalled", int'(dc > 0), 1);
    chk("words_drained_stalled", exp_word.size(), 0);

    // Address wrap at the top of the narrow space
    exp_addr.push_back(10'd1022); exp_addr.push_back(10'd1023);
    exp_addr.push_back(10'd0);    exp_addr.push_back(10'd1);
    exp_word.push_back(4'hE); exp_word.push_back(4'hF);
    exp_word.push_back(4'h0); exp_word.push_back(4'h1);
    play(10'd1022, 11'd4, 1'b0, 4'b1111, -1, dc);
    chk("done_cycle_wrap", dc, 5);
    chk("words_drained_wrap", exp_word.size(), 0);

    // Looping window stopped at cycle 10: 9 reads, 8 accepted words
    for (int i = 0; i < 9; i++) exp_addr.push_back(10'(4 + i % 3));
    for (int i = 0; i < 8; i++) exp_word.push_back(4'(4 + i % 3));
    play(10'd4, 11'd3, 1'b1, 4'b1111, 10, dc);
    chk("no_done_on_stop", dc, -1);
    chk("words_drained_loop", exp_word.size(), 0);
    chk("reads_drained_loop", exp_addr.size(), 0);

    // Zero-length start
    play(10'd0, 11'd0, 1'b0, 4'b1111, -1, dc);
    chk("done_cycle_len0", dc, 1);

    // start and stop together in IDLE
    @(posedge clk); #1;
    base = '0; length = 11'd4; loop = 1'b0; start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    @(negedge clk);
    chk("startstop_busy", int'(busy), 0);
    chk("startstop_enaB", int'(ram_enaB), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("startstop_done", int'(done), 0);

    // Load attempt during RUN, then reset mid-playback
    exp_addr.push_back(10'd0); exp_addr.push_back(10'd1);
    @(posedge clk); #1;
    base = '0; length = 11'd8; loop = 1'b1; start = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; ld_valid = 1'b1; ld_addr = 8'd0; ld_data = 16'hFFFF;
    @(negedge clk);
    chk("run_ld_ready", int'(ld_ready), 0);
    chk("run_no_write", int'(ram_enaA | ram_weA), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    ld_valid = 1'b0; rstn = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_vals("reset_mid");
    chk("reads_drained_reset", exp_addr.size(), 0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // RAM word 0 must be intact after the blocked load and the reset
    for (int i = 0; i < 8; i++) begin exp_addr.push_back(10'(i)); exp_word.push_back(4'(i)); end
    play(10'd0, 11'd8, 1'b0, 4'b1111, -1, dc);
    chk("done_cycle_after_reset", dc, 9);
    chk("words_drained_after_reset", exp_word.size(), 0);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
      begin
        #2_000_000;
        n_chk++; n_fail++;
        $display("FAIL watchdog: simulation time limit reached before stimulus completed");
      end
    join_any
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
